game_state_controller: RTL

GAME_STATE_CONTROLLER -- requirements
Module: game_state_controller

---
 rtl/game_state_controller_if.sv | 24 ++
 rtl/game_state_controller.sv | 94 +++++++++
 2 files changed

// File: rtl/game_state_controller_if.sv
// Signal bundle between the snake game datapath and its state controller.
// The master side drives buttons/score/collision; the slave side reports state.
interface game_state_controller_if #(
    parameter int unsigned N_BUTTONS = 4,
    parameter int unsigned SCORE_W   = 4
);
    logic [N_BUTTONS-1:0] PUSH_BUTTONS;
    logic                 PAUSE_BTN;
    logic [SCORE_W-1:0]   SCORE_IN;
    logic                 COLLISION;
    logic [2:0]           STATE_OUT;
    logic                 GAME_START;
    logic                 GAME_OVER;

    modport master (
        output PUSH_BUTTONS, PAUSE_BTN, SCORE_IN, COLLISION,
        input  STATE_OUT, GAME_START, GAME_OVER
    );

    modport slave (
        input  PUSH_BUTTONS, PAUSE_BTN, SCORE_IN, COLLISION,
        output STATE_OUT, GAME_START, GAME_OVER
    );
endinterface

// File: rtl/game_state_controller.sv
// Top-level game flow FSM: IDLE -> PLAY <-> PAUSE, PLAY -> WIN/LOSE -> IDLE,
// driven by rising-edge button presses, score threshold and collision level.
module game_state_controller #(
    parameter int unsigned N_BUTTONS = 4,
    parameter int unsigned SCORE_W   = 4,
    parameter int unsigned WIN_SCORE = 10,
    parameter int unsigned END_HOLD  = 50000000
) (
    input  logic                   CLOCK,
    input  logic                   RESET,
    game_state_controller_if.slave bus
);

    localparam int unsigned HOLD_W = (END_HOLD == 0) ? 1 : $clog2(END_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((END_HOLD == 0) ? 0 : END_HOLD - 1);
    localparam logic [SCORE_W-1:0] WIN_LIMIT = SCORE_W'(WIN_SCORE);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_PLAY  = 3'b001,
        ST_WIN   = 3'b010,
        ST_LOSE  = 3'b011,
        ST_PAUSE = 3'b100
    } state_e;

    state_e               state_q, state_d;
    logic [N_BUTTONS-1:0] btn_prev_q;
    logic                 pause_prev_q;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic                 game_start_q, game_start_d;
    logic                 game_over_q, game_over_d;

    logic press_c;
    logic pause_press_c;
    logic score_win_c;
    logic hold_done_c;

    assign press_c       = |(bus.PUSH_BUTTONS & ~btn_prev_q);
    assign pause_press_c = bus.PAUSE_BTN & ~pause_prev_q;
    assign score_win_c   = (bus.SCORE_IN >= WIN_LIMIT);
    assign hold_done_c   = (END_HOLD != 0) && (hold_q == HOLD_LAST);

    // Next state, hold counter and registered output decode.
    always_comb begin
        state_d      = state_q;
        hold_d       = '0;
        game_start_d = 1'b0;
        game_over_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (press_c) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (score_win_c)        state_d = ST_WIN;
                else if (bus.COLLISION) state_d = ST_LOSE;
                else if (pause_press_c) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (pause_press_c) state_d = ST_PLAY;
            end
            ST_WIN, ST_LOSE: begin
                if (press_c || hold_done_c) state_d = ST_IDLE;
                else                        hold_d  = hold_q + HOLD_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        game_start_d = (state_q == ST_IDLE) && (state_d == ST_PLAY);
        game_over_d  = (state_d == ST_WIN) || (state_d == ST_LOSE);
    end

    // Edge-detect history loads every cycle so buttons held through reset stay quiet.
    always_ff @(posedge CLOCK) begin
        btn_prev_q   <= bus.PUSH_BUTTONS;
        pause_prev_q <= bus.PAUSE_BTN;
        if (RESET) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            game_start_q <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            game_start_q <= game_start_d;
            game_over_q  <= game_over_d;
        end
    end

    assign bus.STATE_OUT  = state_q;
    assign bus.GAME_START = game_start_q;
    assign bus.GAME_OVER  = game_over_q;

endmodule
